alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
- Parametrised successor to the single-alarm register.
- Holds NUM_ALARMS independently settable alarm times, each with an arm bit.
- Compares each armed alarm against the running time on every minute boundary.
- Runs a per-channel ring/snooze/timeout state machine and drives a combined ring output to the annunciator.
- Sits between the button/mode decoder (edit strobes) and the timekeeper (current time and minute tick).

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..8).
- SEL_W, 2, width of channel select; must be at least clog2(NUM_ALARMS), minimum 1.
- SNOOZE_MIN, 9, minute ticks spent snoozed before re-ringing (1..63).
- RING_TIMEOUT_MIN, 5, minute ticks of unattended ringing before auto-stop (1..63).
- MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze acts as dismiss.

Ports:
- sys_clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sel, input, SEL_W, channel addressed by edit strobes and readback.
- inc_hours_en, input, 1, one-cycle strobe: step hours of the selected channel.
- inc_minutes_en, input, 1, one-cycle strobe: step minutes of the selected channel.
- dec_mode, input, 1, 1 = strobes decrement, 0 = increment.
- arm_toggle, input, 1, one-cycle strobe: invert the arm bit of the selected channel.
- cur_hours, input, 5, current hour (0..23).
- cur_minutes, input, 6, current minute (0..59).
- minute_tick, input, 1, one-cycle pulse on the cycle the timekeeper enters a new minute; cur_* already show the new value.
- snooze_req, input, 1, one-cycle strobe.
- dismiss_req, input, 1, one-cycle strobe.
- sel_hours, output, 5, hours of the selected channel.
- sel_minutes, output, 6, minutes of the selected channel.
- armed, output, NUM_ALARMS, arm bits.
- ringing, output, NUM_ALARMS, per-channel ringing.
- alarm_active, output, 1, OR of ringing.

Behaviour:
- Reset (async, rst_n low): all hours=0, minutes=0, armed=0, every FSM in IDLE, snooze counters=0, ring/snooze timers=0. All outputs are 0.
- sel_hours/sel_minutes: combinational readback of the channel at sel. A sel value >= NUM_ALARMS reads 0 and ignores all edit strobes.
- Edit priority within a cycle: inc_hours_en > inc_minutes_en. Only one field changes per cycle. arm_toggle is independent and can coincide with an edit.
- Hours wrap: inc 23->0, dec 0->23. Minutes wrap: inc 59->0, dec 0->59. No carry between fields.
- A match is evaluated only in a cycle with minute_tick=1. Match = armed && stored hours==cur_hours && stored minutes==cur_minutes. Stored values are the pre-edit register values of that cycle.
- Per-channel FSM states: IDLE, RINGING, SNOOZED.
  - IDLE -> RINGING on match. Clear the snooze count and the timer.
  - RINGING: ringing=1. The timer counts minute_ticks.
    - dismiss_req -> IDLE.
    - snooze_req with snooze count < MAX_SNOOZE -> SNOOZED, count+1, timer cleared.
    - snooze_req with count == MAX_SNOOZE -> IDLE.
    - Timer reaching RING_TIMEOUT_MIN -> IDLE.
  - SNOOZED: ringing=0. The timer counts minute_ticks.
    - On reaching SNOOZE_MIN -> RINGING, timer cleared.
    - dismiss_req -> IDLE.
    - A fresh match in SNOOZED is ignored.
- snooze_req and dismiss_req apply to every channel in RINGING (dismiss also hits SNOOZED). If both arrive in the same cycle, dismiss wins.
- A request coinciding with minute_tick takes priority over timer expiry and match for that channel.
- Disarming a channel (arm_toggle while armed) forces it to IDLE in the same edge. Arming does not trigger a ring until the next matching minute_tick.
- Editing time fields does not affect a channel in RINGING or SNOOZED.
- Latency: ringing asserts on the edge following the matching minute_tick cycle (1 cycle). alarm_active is the combinational OR of the registered ringing bits.
- Multiple channels can ring at once; each keeps its own counters.

Decomposition:
- Shared package alarm_pkg:
  - state encoding (IDLE=2'd0, RINGING=2'd1, SNOOZED=2'd2),
  - HOUR_MAX=23, MIN_MAX=59, HOUR_W=5, MIN_W=6,
  - wrap-step helper functions for hours and minutes.
- Sub-module alarm_channel: one channel's time registers, arm bit, FSM, timer and snooze counter. Instanced NUM_ALARMS times by a generate loop in alarm_bank. Channel inputs are the decoded per-channel edit and arm strobes.

Test Plan:
- Reset, sel=1, three inc_minutes_en with dec_mode=0 -> sel_minutes=3. Then dec_mode=1, four strobes -> 59. Hours dec from 0 -> 23. Channel 0 readback stays 0.
- Ch2 set 07:30, armed. Drive cur=07:30 with minute_tick -> ringing=4'b0100 next cycle, alarm_active=1. Same setup with ch2 unarmed -> no ring.
- Ch0 ringing, snooze_req -> ringing[0]=0. Nine minute_ticks -> ringing[0]=1. Repeat to MAX_SNOOZE=3, then a fourth snooze_req -> IDLE, and no re-ring after 9 more ticks.
- Ch1 ringing with no requests, 5 minute_ticks -> ringing[1]=0. Ch1 and ch3 matching the same tick both ring. One dismiss_req clears both. snooze_req+dismiss_req in the same cycle -> IDLE.
- Ch0 ringing, arm_toggle on sel=0 -> ringing[0]=0, armed[0]=0 next edge. rst_n pulsed low mid-snooze -> all outputs 0 immediately, asynchronously.
- inc_hours_en+inc_minutes_en in the same cycle -> only hours change. Edit on the matching tick cycle -> match uses the old value.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, field limits and wrap-step helpers for the alarm bank.
package alarm_pkg;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnoozed = 2'd2
  } alarm_state_e;

  function automatic logic [HOUR_W-1:0] step_hours(input logic [HOUR_W-1:0] h,
                                                   input logic               dec);
    if (dec) begin
      return (h == '0) ? HOUR_W'(HOUR_MAX) : h - HOUR_W'(1);
    end
    return (h >= HOUR_W'(HOUR_MAX)) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] step_minutes(input logic [MIN_W-1:0] m,
                                                    input logic              dec);
    if (dec) begin
      return (m == '0) ? MIN_W'(MIN_MAX) : m - MIN_W'(1);
    end
    return (m >= MIN_W'(MIN_MAX)) ? '0 : m + MIN_W'(1);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, arm bit and the ring/snooze/timeout state machine.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              inc_hours,
  input  logic              inc_minutes,
  input  logic              dec_mode,
  input  logic              arm_toggle,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  input  logic              minute_tick,
  input  logic              snooze_req,
  input  logic              dismiss_req,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic              armed,
  output logic              ringing
);

  localparam int unsigned TimerW = 6;
  localparam int unsigned CntW   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d;
  logic              armed_q, armed_d;

  alarm_state_e      state_q;
  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_inc;
  logic [CntW-1:0]   snooze_cnt_q;
  logic              ringing_q;
  logic              match;
  logic              disarm;

  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    armed_d   = armed_q ^ arm_toggle;
    if (inc_hours) begin
      hours_d = step_hours(hours_q, dec_mode);
    end else if (inc_minutes) begin
      minutes_d = step_minutes(minutes_q, dec_mode);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_q   <= '0;
      minutes_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      armed_q   <= armed_d;
    end
  end

  // Match sees the pre-edit time and arm bit, so a same-cycle arm never rings.
  assign match = minute_tick && armed_q && (hours_q == cur_hours) &&
                 (minutes_q == cur_minutes);
  assign disarm    = arm_toggle && armed_q;
  assign timer_inc = timer_q + TimerW'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      snooze_cnt_q <= '0;
      ringing_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match && !disarm) begin
            state_q      <= StRinging;
            timer_q      <= '0;
            snooze_cnt_q <= '0;
            ringing_q    <= 1'b1;
          end
        end
        StRinging: begin
          if (disarm || dismiss_req) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            ringing_q <= 1'b0;
          end else if (snooze_req) begin
            timer_q   <= '0;
            ringing_q <= 1'b0;
            if (snooze_cnt_q < CntW'(MAX_SNOOZE)) begin
              state_q      <= StSnoozed;
              snooze_cnt_q <= snooze_cnt_q + CntW'(1);
            end else begin
              state_q <= StIdle;
            end
          end else if (minute_tick) begin
            if (timer_inc == TimerW'(RING_TIMEOUT_MIN)) begin
              state_q   <= StIdle;
              timer_q   <= '0;
              ringing_q <= 1'b0;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end
        StSnoozed: begin
          if (disarm || dismiss_req) begin
            state_q <= StIdle;
            timer_q <= '0;
          end else if (minute_tick) begin
            if (timer_inc == TimerW'(SNOOZE_MIN)) begin
              state_q   <= StRinging;
              timer_q   <= '0;
              ringing_q <= 1'b1;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          timer_q   <= '0;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign armed   = armed_q;
  assign ringing = ringing_q;

endmodule

// File: rtl/alarm_bank.sv
// Bank of independently settable alarm channels with a combined ring output.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS       = 4,
  parameter int unsigned SEL_W            = 2,
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  inc_hours_en,
  input  logic                  inc_minutes_en,
  input  logic                  dec_mode,
  input  logic                  arm_toggle,
  input  logic [HOUR_W-1:0]     cur_hours,
  input  logic [MIN_W-1:0]      cur_minutes,
  input  logic                  minute_tick,
  input  logic                  snooze_req,
  input  logic                  dismiss_req,
  output logic [HOUR_W-1:0]     sel_hours,
  output logic [MIN_W-1:0]      sel_minutes,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_active
);

  logic [NUM_ALARMS-1:0] sel_hit;
  logic [HOUR_W-1:0]     ch_hours   [NUM_ALARMS];
  logic [MIN_W-1:0]      ch_minutes [NUM_ALARMS];

  // A sel beyond the last channel hits nothing, so it reads 0 and edits are dropped.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    assign sel_hit[i] = (sel == SEL_W'(i));

    alarm_channel #(
      .SNOOZE_MIN      (SNOOZE_MIN),
      .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN),
      .MAX_SNOOZE      (MAX_SNOOZE)
    ) u_channel (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .inc_hours  (inc_hours_en && sel_hit[i]),
      .inc_minutes(inc_minutes_en && sel_hit[i]),
      .dec_mode   (dec_mode),
      .arm_toggle (arm_toggle && sel_hit[i]),
      .cur_hours  (cur_hours),
      .cur_minutes(cur_minutes),
      .minute_tick(minute_tick),
      .snooze_req (snooze_req),
      .dismiss_req(dismiss_req),
      .hours      (ch_hours[i]),
      .minutes    (ch_minutes[i]),
      .armed      (armed[i]),
      .ringing    (ringing[i])
    );
  end

  always_comb begin
    sel_hours   = '0;
    sel_minutes = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_hit[i]) begin
        sel_hours   = ch_hours[i];
        sel_minutes = ch_minutes[i];
      end
    end
  end

  assign alarm_active = |ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: edit table plus ring/snooze/timeout sequences.
module tb_alarm_bank;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       inc_hours_en, inc_minutes_en, dec_mode, arm_toggle;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       minute_tick, snooze_req, dismiss_req;
  logic [4:0] sel_hours;
  logic [5:0] sel_minutes;
  logic [3:0] armed, ringing;
  logic       alarm_active;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  alarm_bank #(
    .NUM_ALARMS      (4),
    .SEL_W           (2),
    .SNOOZE_MIN      (9),
    .RING_TIMEOUT_MIN(5),
    .MAX_SNOOZE      (3)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .sel           (sel),
    .inc_hours_en  (inc_hours_en),
    .inc_minutes_en(inc_minutes_en),
    .dec_mode      (dec_mode),
    .arm_toggle    (arm_toggle),
    .cur_hours     (cur_hours),
    .cur_minutes   (cur_minutes),
    .minute_tick   (minute_tick),
    .snooze_req    (snooze_req),
    .dismiss_req   (dismiss_req),
    .sel_hours     (sel_hours),
    .sel_minutes   (sel_minutes),
    .armed         (armed),
    .ringing       (ringing),
    .alarm_active  (alarm_active)
  );

  typedef struct {
    logic [1:0] sel;
    logic       ih, im, dec, arm;
    logic [4:0] exp_h;
    logic [5:0] exp_m;
    logic [3:0] exp_armed;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_strobes();
    inc_hours_en   = 1'b0;
    inc_minutes_en = 1'b0;
    arm_toggle     = 1'b0;
    dec_mode       = 1'b0;
    minute_tick    = 1'b0;
    snooze_req     = 1'b0;
    dismiss_req    = 1'b0;
  endtask

  task automatic edit(input logic [1:0] s, input logic ih, input logic im, input logic dec,
                      input logic arm);
    sel            = s;
    inc_hours_en   = ih;
    inc_minutes_en = im;
    dec_mode       = dec;
    arm_toggle     = arm;
    step();
    clear_strobes();
  endtask

  task automatic set_time(input logic [1:0] ch, input int h, input int m);
    repeat (h) edit(ch, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (m) edit(ch, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick(input int h, input int m);
    cur_hours   = 5'(h);
    cur_minutes = 6'(m);
    minute_tick = 1'b1;
    step();
    minute_tick = 1'b0;
  endtask

  task automatic req(input logic sn, input logic dis);
    snooze_req  = sn;
    dismiss_req = dis;
    step();
    snooze_req  = 1'b0;
    dismiss_req = 1'b0;
  endtask

  initial begin
    //           sel   ih    im    dec   arm   hours  min    armed
    vecs[0]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  6'd1,  4'b0000};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  6'd2,  4'b0000};
    vecs[2]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  6'd3,  4'b0000};
    vecs[3]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd2,  4'b0000};
    vecs[4]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd1,  4'b0000};
    vecs[5]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd0,  4'b0000};
    vecs[6]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd59, 4'b0000};
    vecs[7]  = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 6'd59, 4'b0000};
    vecs[8]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0,  4'b0000};
    vecs[9]  = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  6'd59, 4'b0000};
    vecs[10] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  6'd59, 4'b0010};
    vecs[11] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  6'd59, 4'b0000};
    vecs[12] = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  6'd1,  4'b1000};
    vecs[13] = '{2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  6'd0,  4'b0000};

    rst_n       = 1'b0;
    sel         = 2'd0;
    cur_hours   = 5'd0;
    cur_minutes = 6'd0;
    clear_strobes();
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_armed", 32'(armed), 32'h0);
    check("reset_ringing", 32'(ringing), 32'h0);
    check("reset_active", 32'(alarm_active), 32'h0);
    check("reset_sel_time", {sel_hours, sel_minutes}, 32'h0);
    rst_n = 1'b1;
    step();

    // Edit table.
    for (int i = 0; i < 14; i++) begin
      sel            = vecs[i].sel;
      inc_hours_en   = vecs[i].ih;
      inc_minutes_en = vecs[i].im;
      dec_mode       = vecs[i].dec;
      arm_toggle     = vecs[i].arm;
      step();
      check($sformatf("vec%0d_hours", i), 32'(sel_hours), 32'(vecs[i].exp_h));
      check($sformatf("vec%0d_minutes", i), 32'(sel_minutes), 32'(vecs[i].exp_m));
      check($sformatf("vec%0d_armed", i), 32'(armed), 32'(vecs[i].exp_armed));
    end
    clear_strobes();

    // Ch2 at 07:30: armed rings, disarmed stays quiet.
    set_time(2'd2, 7, 30);
    edit(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ch2_readback", {sel_hours, sel_minutes}, {5'd7, 6'd30});
    check("ch2_armed", 32'(armed), 32'b0100);
    tick(7, 30);
    check("ch2_ring", 32'(ringing), 32'b0100);
    check("ch2_active", 32'(alarm_active), 32'h1);
    req(1'b0, 1'b1);
    check("ch2_dismiss", {alarm_active, ringing}, 32'h0);
    edit(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(7, 30);
    check("ch2_unarmed_no_ring", 32'(ringing), 32'h0);

    // Ch0 snooze cycles up to the snooze limit.
    set_time(2'd0, 1, 0);
    edit(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1, 0);
    check("ch0_ring", 32'(ringing), 32'b0001);
    for (int r = 0; r < 3; r++) begin
      req(1'b1, 1'b0);
      check($sformatf("snooze%0d_quiet", r), 32'(ringing), 32'h0);
      repeat (8) tick(2, 0);
      check($sformatf("snooze%0d_8ticks", r), 32'(ringing), 32'h0);
      tick(2, 0);
      check($sformatf("snooze%0d_rering", r), 32'(ringing), 32'b0001);
    end
    req(1'b1, 1'b0);
    check("snooze_limit_stop", 32'(ringing), 32'h0);
    repeat (9) tick(2, 0);
    check("snooze_limit_idle", 32'(ringing), 32'h0);

    // Ch1 ring timeout, then ch1+ch3 together.
    edit(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    set_time(2'd1, 2, 0);
    edit(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ch1_armed", 32'(armed), 32'b0011);
    tick(2, 0);
    check("ch1_ring", 32'(ringing), 32'b0010);
    repeat (4) tick(3, 0);
    check("ch1_4ticks", 32'(ringing), 32'b0010);
    tick(3, 0);
    check("ch1_timeout", 32'(ringing), 32'h0);
    set_time(2'd3, 2, 0);
    edit(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2, 0);
    check("ch13_ring", 32'(ringing), 32'b1010);
    req(1'b0, 1'b1);
    check("ch13_dismiss", 32'(ringing), 32'h0);
    tick(2, 0);
    check("ch13_ring2", 32'(ringing), 32'b1010);
    req(1'b1, 1'b1);
    check("snz_dis_same", 32'(ringing), 32'h0);
    repeat (9) tick(3, 0);
    check("snz_dis_idle", 32'(ringing), 32'h0);

    // Disarm while ringing, then async reset mid-snooze.
    tick(1, 0);
    check("ch0_ring_again", 32'(ringing), 32'b0001);
    edit(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("disarm_ring", 32'(ringing), 32'h0);
    check("disarm_armed", 32'(armed), 32'b1010);
    edit(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1, 0);
    check("rearm_ring", 32'(ringing), 32'b0001);
    req(1'b1, 1'b0);
    repeat (3) tick(3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_armed", 32'(armed), 32'h0);
    check("async_rst_ring", {alarm_active, ringing}, 32'h0);
    check("async_rst_time", {sel_hours, sel_minutes}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Both strobes: only hours move. Edit on the matching tick uses the old time.
    edit(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_strobes", {sel_hours, sel_minutes}, {5'd1, 6'd0});
    edit(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    sel            = 2'd0;
    inc_minutes_en = 1'b1;
    tick(1, 0);
    clear_strobes();
    check("edit_on_tick_ring", 32'(ringing), 32'b0001);
    check("edit_on_tick_min", 32'(sel_minutes), 32'd1);
    req(1'b0, 1'b1);
    tick(1, 0);
    check("old_time_no_match", 32'(ringing), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
